// File: rtl/mips_run_pkg.sv
// Shared types and default constants for the Mips32 run sequencer.
// Contents: run_state_e (controller phase), DEF_RESET_CYCLES, DEF_TIMEOUT.
package mips_run_pkg;

  // Controller phases: stream image, hold core in reset, supervise run, report.
  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } run_state_e;

  localparam int unsigned DEF_RESET_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT      = 1990;

endpackage

// File: rtl/mips_run_controller.sv
// Run sequencer for the Mips32 harness: streams a program image into the
// instruction memory, holds the core in reset for a fixed window, then
// supervises execution until the core halts or the cycle budget expires.
// Ports:
//   clock, reset                 - clock and async active-high reset
//   ld_valid/ld_ready/ld_data/ld_last - program word stream
//   restart                      - pulse, honoured only once the run is done
//   mem_we/mem_waddr/mem_wdata   - instruction-memory write port (combinational)
//   core_reset, core_halted      - core control and status
//   done, timed_out, cycles      - run result (registered)
module mips_run_controller
  import mips_run_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  restart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_reset,
  input  logic                  core_halted,
  output logic                  done,
  output logic                  timed_out,
  output logic [CNT_WIDTH-1:0]  cycles
);

  localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] WPTR_FULL   = '1;
  localparam logic [RST_CNT_W-1:0]  RST_LAST    = RST_CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT);

  run_state_e            r_state;
  run_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [RST_CNT_W-1:0]  r_rst_cnt;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic                  r_done;
  logic                  r_timed_out;
  logic                  r_core_reset;

  logic                  w_accept;
  logic                  w_load_exit;
  logic                  w_rst_exit;
  logic [CNT_WIDTH-1:0]  w_cycles_inc;
  logic                  w_budget_hit;

  // The word at the full address is the last one the memory can take.
  assign w_accept     = (r_state == LOAD) && ld_valid;
  assign w_load_exit  = w_accept && (ld_last || (r_wptr == WPTR_FULL));
  assign w_rst_exit   = (r_rst_cnt == RST_LAST);
  assign w_cycles_inc = r_cycles + CNT_WIDTH'(1);
  assign w_budget_hit = (w_cycles_inc == CNT_TIMEOUT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a halt takes priority over the budget.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:     if (w_load_exit) w_state_nxt = CORE_RST;
      CORE_RST: if (w_rst_exit) w_state_nxt = RUN;
      RUN:      if (core_halted || w_budget_hit) w_state_nxt = DONE;
      DONE:     if (restart) w_state_nxt = LOAD;
      default:  w_state_nxt = LOAD;
    endcase
  end

  // Combinational outputs: load handshake and memory write port.
  // Writes are suppressed while reset is asserted since no word is consumed then.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = r_wptr;
    mem_wdata = ld_data;
    if (r_state == LOAD) begin
      ld_ready = 1'b1;
      mem_we   = ld_valid && !reset;
    end
  end

  // Datapath: write pointer, reset window counter, run counter and result flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rst_cnt    <= '0;
      r_cycles     <= '0;
      r_done       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_core_reset <= (w_state_nxt != RUN);
      r_done       <= (w_state_nxt == DONE);
      case (r_state)
        LOAD: begin
          if (w_accept) r_wptr <= r_wptr + ADDR_WIDTH'(1);
          if (w_load_exit) begin
            r_rst_cnt <= '0;
            r_cycles  <= '0;
          end
        end
        CORE_RST: r_rst_cnt <= r_rst_cnt + RST_CNT_W'(1);
        RUN: begin
          if (core_halted) begin
            r_timed_out <= 1'b0;
          end else begin
            r_cycles    <= w_cycles_inc;
            r_timed_out <= w_budget_hit;
          end
        end
        DONE: begin
          if (restart) begin
            r_wptr      <= '0;
            r_cycles    <= '0;
            r_timed_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_reset = r_core_reset;
  assign done       = r_done;
  assign timed_out  = r_timed_out;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_mips_run_controller.sv
// Self-checking bench for mips_run_controller: directed vector table,
// hand-written corner sequences and a randomized run against a phase-level model.
module tb_mips_run_controller;
  import mips_run_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned RC    = DEF_RESET_CYCLES;
  localparam int unsigned CW    = 16;
  localparam int unsigned TO    = DEF_TIMEOUT;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic          restart = 1'b0;
  logic          core_halted = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, mem_we, core_reset, done, timed_out;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] cycles;

  mips_run_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_CYCLES(RC), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .restart(restart), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .core_reset(core_reset),
    .core_halted(core_halted), .done(done), .timed_out(timed_out), .cycles(cycles)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side memory written by the DUT, and the expected image.
  logic [DW-1:0] dut_mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int wr_cnt  = 0;
  int wr_last = -1;

  // Phase-level reference model.
  bit m_loading, m_running, m_done, m_to;
  int m_wptr, m_hold, m_cycles;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1; m_running = 0; m_done = 0; m_to = 0;
    m_wptr = 0; m_hold = 0; m_cycles = 0;
  endtask

  task automatic model_update();
    if (m_loading) begin
      if (ld_valid) begin
        exp_mem[m_wptr] = ld_data;
        if (ld_last || m_wptr == int'(DEPTH) - 1) begin
          m_loading = 0; m_hold = RC; m_cycles = 0;
        end
        m_wptr = (m_wptr + 1) % int'(DEPTH);
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_running = 1;
    end else if (m_running) begin
      if (core_halted) begin
        m_running = 0; m_done = 1; m_to = 0;
      end else begin
        m_cycles++;
        if (m_cycles == int'(TO)) begin
          m_running = 0; m_done = 1; m_to = 1;
        end
      end
    end else if (m_done && restart) begin
      m_loading = 1; m_wptr = 0; m_done = 0; m_to = 0; m_cycles = 0;
    end
  endtask

  task automatic check_model();
    chk("mdl_ld_ready", ld_ready, m_loading);
    chk("mdl_mem_we", mem_we, m_loading && ld_valid);
    chk("mdl_mem_waddr", mem_waddr, m_wptr);
    if (m_loading && ld_valid) chk("mdl_mem_wdata", mem_wdata, ld_data);
    chk("mdl_core_reset", core_reset, !m_running);
    chk("mdl_done", done, m_done);
    chk("mdl_timed_out", timed_out, m_to);
    chk("mdl_cycles", cycles, m_cycles);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read 2 units later.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit h, input bit r);
    ld_valid = v; ld_data = d; ld_last = l; core_halted = h; restart = r;
    #2;
  endtask

  task automatic step();
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    c_we = mem_we; c_addr = mem_waddr; c_data = mem_wdata;
    @(posedge clock);
    if (c_we) begin
      dut_mem[c_addr] = c_data;
      wr_cnt++;
      wr_last = int'(c_addr);
    end
    model_update();
    #1;
  endtask

  task automatic tick(input bit v, input logic [DW-1:0] d, input bit l, input bit h, input bit r);
    drive(v, d, l, h, r);
    check_model();
    step();
  endtask

  task automatic wait_release(output int n);
    n = 0;
    drive(0, '0, 0, 0, 0);
    while (core_reset && n < 20) begin
      n++;
      check_model();
      step();
      drive(0, '0, 0, 0, 0);
    end
  endtask

  task automatic mem_compare(input string nm);
    int bad;
    int first;
    bad = 0; first = -1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (dut_mem[i] !== exp_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_mem_mismatch_words(first=%0d)", nm, first), bad, 0);
  endtask

  typedef struct {
    bit v; logic [DW-1:0] d; bit l; bit h; bit r;
    bit e_rdy; bit e_we; int e_addr; bit e_cr; bit e_done; bit e_to; int e_cyc;
  } vec_t;

  vec_t tbl[13];
  logic [DW-1:0] img[13];

  initial begin
    int hold;
    int k;
    int g;
    int sent;
    int after_full;
    bit rv, rl, rh, rr;

    for (int i = 0; i < int'(DEPTH); i++) begin
      dut_mem[i] = SENT;
      exp_mem[i] = SENT;
    end
    model_reset();

    // Reset values, with a word offered that must not be written.
    ld_valid = 1'b1;
    #12;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_cycles", cycles, 0);
    ld_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed vector table: short load with a gap, reset window, short run, restart.
    tbl[0]  = '{1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 2};
    tbl[12] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].h, tbl[i].r);
      chk($sformatf("tbl%0d_ld_ready", i), ld_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_mem_waddr", i), mem_waddr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].d);
      chk($sformatf("tbl%0d_core_reset", i), core_reset, tbl[i].e_cr);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_timed_out", i), timed_out, tbl[i].e_to);
      chk($sformatf("tbl%0d_cycles", i), cycles, tbl[i].e_cyc);
      check_model();
      step();
    end
    chk("tbl_mem0", dut_mem[0], 32'hA000_0000);
    chk("tbl_mem2", dut_mem[2], 32'hA000_0002);

    // 13-word image back-to-back, then halt on the 50th run cycle.
    for (int i = 0; i < 13; i++) img[i] = 32'h0100_0000 + 32'(i * 16'h0301);
    img[0]  = 32'd6494246;
    img[12] = 32'd0;
    wr_cnt = 0;
    for (int i = 0; i < 13; i++) tick(1, img[i], i == 12, 0, 0);
    chk("A_write_count", wr_cnt, 13);
    drive(0, '0, 0, 0, 0);
    chk("A_ready_after_last", ld_ready, 0);
    wait_release(hold);
    chk("A_core_reset_hold", hold, RC);
    for (int i = 1; i <= 50; i++) begin
      drive(0, '0, 0, i == 50, 0);
      check_model();
      step();
    end
    drive(0, '0, 0, 0, 0);
    chk("A_done", done, 1);
    chk("A_timed_out", timed_out, 0);
    chk("A_cycles", cycles, 49);
    chk("A_core_reset_back", core_reset, 1);
    for (int i = 0; i < 13; i++) chk($sformatf("A_mem%0d", i), dut_mem[i], img[i]);
    chk("A_mem13_untouched", dut_mem[13], SENT);

    // Budget expiry with no halt.
    tick(0, '0, 0, 0, 1);
    tick(1, 32'h0000_1234, 1, 0, 0);
    wait_release(hold);
    chk("B_core_reset_hold", hold, RC);
    k = 0;
    while (!done && k < 3000) begin
      k++;
      check_model();
      step();
      drive(0, '0, 0, 0, 0);
    end
    chk("B_run_cycles_to_done", k, TO);
    chk("B_done", done, 1);
    chk("B_timed_out", timed_out, 1);
    chk("B_cycles", cycles, TO);

    // Halt on the budget cycle wins; restart during RUN is ignored.
    tick(0, '0, 0, 0, 1);
    tick(1, 32'h0000_5678, 0, 0, 0);
    tick(1, 32'h0000_9ABC, 1, 0, 0);
    wait_release(hold);
    for (int i = 1; i <= int'(TO); i++) begin
      drive(0, '0, 0, i == int'(TO), i == 5);
      check_model();
      step();
    end
    drive(0, '0, 0, 0, 0);
    chk("C_done", done, 1);
    chk("C_timed_out", timed_out, 0);
    chk("C_cycles", cycles, TO - 1);
    tick(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 0);
    chk("C_restart_ld_ready", ld_ready, 1);
    chk("C_restart_done", done, 0);
    chk("C_restart_cycles", cycles, 0);
    chk("C_restart_waddr", mem_waddr, 0);

    // 300 words with gaps and no last marker: memory fills at 256.
    wr_cnt = 0; sent = 0; after_full = 0;
    for (int c = 0; c < 2000; c++) begin
      rv = (sent < 300) && ($urandom_range(0, 3) != 0);
      drive(rv, $urandom, 0, 0, 0);
      if (rv && ld_ready) sent++;
      if (!ld_ready) begin
        after_full++;
        if (after_full > 8) break;
      end
      check_model();
      step();
    end
    chk("D_write_count", wr_cnt, 256);
    chk("D_last_addr", wr_last, 255);
    chk("D_words_accepted", sent, 256);
    chk("D_ld_ready_after_full", ld_ready, 0);
    mem_compare("D");

    // Async reset mid-RUN at cycles=100, then reload two words.
    g = 0;
    drive(0, '0, 0, 0, 0);
    while (cycles != CW'(100) && g < 500) begin
      g++;
      check_model();
      step();
      drive(0, '0, 0, 0, 0);
    end
    chk("E_reached_100", cycles, 100);
    reset = 1'b1;
    #1;
    chk("E_rst_ld_ready", ld_ready, 1);
    chk("E_rst_mem_we", mem_we, 0);
    chk("E_rst_mem_waddr", mem_waddr, 0);
    chk("E_rst_core_reset", core_reset, 1);
    chk("E_rst_done", done, 0);
    chk("E_rst_timed_out", timed_out, 0);
    chk("E_rst_cycles", cycles, 0);
    model_reset();
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    wr_cnt = 0;
    tick(1, 32'hE000_0000, 0, 0, 0);
    tick(1, 32'hE000_0001, 1, 0, 0);
    chk("E_write_count", wr_cnt, 2);
    chk("E_mem0", dut_mem[0], 32'hE000_0000);
    chk("E_mem1", dut_mem[1], 32'hE000_0001);
    chk("E_last_addr", wr_last, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      rv = $urandom_range(0, 1) != 0;
      rl = $urandom_range(0, 15) == 0;
      rh = $urandom_range(0, 299) == 0;
      rr = $urandom_range(0, 7) == 0;
      tick(rv, $urandom, rl, rh, rr);
    end
    mem_compare("F");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_run_controller.md
# mips_run_controller

Run sequencer for the Mips32 simulation harness. Streams a program image into the single-write-port instruction memory and holds the core in reset while it does so. Then releases the core for a fixed reset window and supervises execution until `halted` or a cycle-budget timeout. It replaces hand-written `initial` memory images and free-running cycle counters with one reusable, restartable controller.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width (depth 2^ADDR_WIDTH).
- `DATA_WIDTH`, 32: instruction word width.
- `RESET_CYCLES`, 4: cycles `core_reset` stays high after load completes; must be ≥1.
- `CNT_WIDTH`, 16: width of run-cycle counter.
- `TIMEOUT`, 1990: run-cycle budget; 1 ≤ TIMEOUT < 2^CNT_WIDTH.
- `clock  in  1`  single clock, rising edge.
- `reset  in  1`  asynchronous, active-high.
- `ld_valid  in  1`  program word valid.
- `ld_ready  out  1`  controller accepts word.
- `ld_data  in  DATA_WIDTH`  program word.
- `ld_last  in  1`  final word of image, qualified by `ld_valid`.
- `restart  in  1`  single-cycle pulse; honoured only in DONE.
- `mem_we  out  1`  instruction-memory write enable.
- `mem_waddr  out  ADDR_WIDTH`  write address.
- `mem_wdata  out  DATA_WIDTH`  write data.
- `core_reset  out  1`  reset to Mips32.
- `core_halted  in  1`  Mips32 `halted`.
- `done  out  1`  run finished (sticky).
- `timed_out  out  1`  run ended by budget, valid when `done`.
- `cycles  out  CNT_WIDTH`  run cycles elapsed.

## Operation
- States: LOAD, CORE_RST, RUN, DONE. Async reset → LOAD, `wptr`=0, rst counter=0, `cycles`=0, `done`=0, `timed_out`=0.
- LOAD: `ld_ready`=1. Accept = `ld_valid & ld_ready`. On accept, `mem_we`=1, `mem_waddr`=`wptr`, `mem_wdata`=`ld_data` (combinational pass-through); `wptr`++ at the edge. If the accepted word has `ld_last`=1, or `wptr`=2^ADDR_WIDTH−1 (memory full), go to CORE_RST. Words beyond full are never accepted.
- CORE_RST: counts RESET_CYCLES cycles, then goes to RUN. `cycles` is cleared on entry.
- RUN: each cycle, sample `core_halted`.
  - `core_halted`=1: go to DONE, `timed_out`=0, `cycles` unchanged.
  - Otherwise `cycles`++. If the incremented value equals TIMEOUT: go to DONE, `timed_out`=1.
- DONE: `done`=1, `cycles` and `timed_out` frozen. `restart` → LOAD with `wptr`=0 and `done`/`timed_out`/`cycles` cleared. `restart` in any other state is ignored.
- `core_reset`=1 in LOAD, CORE_RST and DONE, and 0 only in RUN. It is also 1 while `reset` is asserted.
- `ld_ready`=0 and `mem_we`=0 outside LOAD.
- Memory contents beyond the last loaded word are untouched. The controller performs no zero-fill.

## Timing
- Reset values: `ld_ready`=1, `mem_we`=0, `mem_waddr`=0, `core_reset`=1, `done`=0, `timed_out`=0, `cycles`=0.
- Load throughput: one word per cycle. `ld_valid` gaps simply stall; there is no timeout in LOAD.
- Edge accepting the last word → `ld_ready`=0 the next cycle.
- `core_reset` is high for exactly RESET_CYCLES cycles after LOAD exits, then low on the first RUN cycle.
- Halt latency: `core_halted` sampled high at edge N → `done`=1 after edge N.
- Halt and timeout in the same cycle: halt wins, `timed_out`=0.
- Async reset mid-RUN or mid-LOAD aborts immediately to reset values. Already-written memory words remain in the memory.
- All state is registered. The only combinational outputs are the `mem_*` signals and `ld_ready` (decoded from state).

## Structure
- Package `mips_run_pkg` holds:
  - the state enum `run_state_e` {LOAD, CORE_RST, RUN, DONE};
  - default constants `DEF_RESET_CYCLES`=4 and `DEF_TIMEOUT`=1990.
- Single module. No sub-module is warranted; the rst and run counters are inline.
- The harness top instantiates the controller, the memory, the core and a program-stream source.

## Test plan
- Load the 13-word image (word0=6494246, word12=0) back-to-back with `ld_last` on word 12 → 13 `mem_we` pulses at addr 0..12 with matching data. `ld_ready` is 0 next cycle. `core_reset` stays high 4 more cycles, then goes low.
- After load, drive `core_halted` high on the 50th RUN cycle → `done`=1, `timed_out`=0, `cycles`=49. `core_reset` goes back to 1.
- Never assert halt, TIMEOUT=1990 → `done`=1, `timed_out`=1, `cycles`=1990 exactly 1990 RUN cycles after release.
- Stream 300 words with no `ld_last` and random `ld_valid` gaps → exactly 256 writes, addr 0..255. The 257th word is never accepted and the controller enters CORE_RST.
- Assert `reset` mid-RUN (`cycles`=100) → same-cycle return to reset values and LOAD. Reload 2 words → writes at addr 0,1.
- Assert `core_halted` exactly on the TIMEOUT cycle → `timed_out`=0. Then pulse `restart` → LOAD, `done`=0, `cycles`=0. A `restart` pulse during RUN has no effect.
